// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
package mult_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} mult_state_t;

  localparam int DEFAULT_N = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/step_counter.sv
// Down-counter that paces the RUN phase; reloads to n and flags the final step.
module step_counter
  import mult_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic clock,
  input  logic reset,
  input  logic load_cnt,
  input  logic dec,
  output logic last
);

  localparam int W = cnt_width(n);

  logic [W-1:0] cnt_q, cnt_d;

  // Holds at zero rather than wrapping, so a stray dec can never restart a run.
  always_comb begin
    cnt_d = cnt_q;
    if (load_cnt) begin
      cnt_d = W'(n);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/mult_controller.sv
// Sequencer for the shift-add multiplier: load, n add/shift steps, capture, hold until ack.
module mult_controller
  import mult_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           ack,
  input  logic           q0,
  input  logic [2*n-1:0] product_in,
  output logic           load,
  output logic           add_shift,
  output logic           shift,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product
);

  mult_state_t    state_q, state_d;
  logic           load_q, run_q, busy_q, done_q;
  logic [2*n-1:0] product_q, product_d;
  logic           load_cnt, dec, last;

  assign load_cnt = (state_q == LOAD);
  assign dec      = (state_q == RUN);

  step_counter #(.n(n)) u_step_counter (
    .clock    (clock),
    .reset    (reset),
    .load_cnt (load_cnt),
    .dec      (dec),
    .last     (last)
  );

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (last) state_d = CAPTURE;
      CAPTURE: begin
        state_d   = DONE;
        product_d = product_in;
      end
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= (state_d == LOAD);
      run_q     <= (state_d == RUN);
      busy_q    <= (state_d == LOAD) || (state_d == RUN) || (state_d == CAPTURE);
      done_q    <= (state_d == DONE);
      product_q <= product_d;
    end
  end

  assign load      = load_q;
  assign add_shift = run_q & q0;
  assign shift     = run_q & ~q0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;

endmodule
